// File: rtl/harris_pkg.sv
// Shared defaults, FSM state type and helpers for the Harris corner
// non-maximum-suppression stage.
package harris_pkg;

  localparam int DEF_IMG_W  = 128;
  localparam int DEF_IMG_H  = 128;
  localparam int DEF_RESP_W = 32;

  localparam logic signed [DEF_RESP_W-1:0] RESP_MIN = {1'b1, {(DEF_RESP_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Saturating 16-bit increment for the per-frame corner counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic inc);
    return (inc && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/harris_line_buffer.sv
// One row of response history: registered read, read-before-write, with a
// separate write address so rows can be cascaded through a registered read.
module harris_line_buffer
  import harris_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W,
  parameter int WIDTH = DEF_RESP_W,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic [AW-1:0]    i_rd_addr,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (i_en) begin
      o_rd_data          <= r_mem[i_rd_addr];
      r_mem[i_wr_addr]   <= i_wr_data;
    end
  end

endmodule

// File: rtl/harris_corner_nms.sv
// 3x3 non-maximum suppression plus threshold on a raster Harris response
// stream; emits corner coordinates and a per-frame corner count.
module harris_corner_nms
  import harris_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int RESP_W = DEF_RESP_W,
  parameter int X_W    = 8,
  parameter int Y_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RESP_W-1:0] resp,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] threshold,
  output logic              corner_valid,
  output logic [X_W-1:0]    corner_x,
  output logic [Y_W-1:0]    corner_y,
  output logic              frame_done,
  output logic [15:0]       corner_count
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

  logic [X_W-1:0]           r_x, r_x_prev;
  logic [Y_W-1:0]           r_y;
  state_t                   r_state, w_state_next;
  logic                     w_latch_thr;
  logic signed [RESP_W-1:0] r_thresh;
  logic                     w_last;

  logic signed [RESP_W-1:0] w_lb1_rd, w_lb2_rd;
  logic signed [RESP_W-1:0] r_resp_d;
  logic signed [RESP_W-1:0] w_col2 [3];
  logic signed [RESP_W-1:0] r_win  [3][2];
  logic signed [RESP_W-1:0] w_grid [3][3];
  logic signed [RESP_W-1:0] w_centre;
  logic [8:0]               w_pass;
  logic                     w_corner;

  logic                     r_s1_eval, r_s1_last;
  logic [X_W-1:0]           r_s1_x;
  logic [Y_W-1:0]           r_s1_y;
  logic [15:0]              r_count, w_count_inc;

  assign w_last = resp_valid && (r_x == X_LAST) && (r_y == Y_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_x      <= '0;
      r_y      <= '0;
      r_x_prev <= '0;
    end else if (resp_valid) begin
      r_x_prev <= r_x;
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= (r_y == Y_LAST) ? '0 : r_y + Y_W'(1);
      end else begin
        r_x <= r_x + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_thresh <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_latch_thr) r_thresh <= threshold;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_latch_thr  = 1'b0;
    case (r_state)
      IDLE: if (resp_valid) begin
        w_latch_thr  = 1'b1;
        w_state_next = FILL;
      end
      FILL: if (resp_valid && (r_x == '0) && (r_y == Y_W'(2))) w_state_next = RUN;
      RUN:  if (w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Row y-2 is fed from row y-1's registered read, so it is written one
  // accepted pixel late at the previous column.
  harris_line_buffer #(.DEPTH(IMG_W), .WIDTH(RESP_W), .AW(AW)) u_lb_row1 (
    .clk       (clk),
    .i_en      (resp_valid),
    .i_rd_addr (r_x[AW-1:0]),
    .i_wr_addr (r_x[AW-1:0]),
    .i_wr_data (resp),
    .o_rd_data (w_lb1_rd)
  );

  harris_line_buffer #(.DEPTH(IMG_W), .WIDTH(RESP_W), .AW(AW)) u_lb_row2 (
    .clk       (clk),
    .i_en      (resp_valid),
    .i_rd_addr (r_x[AW-1:0]),
    .i_wr_addr (r_x_prev[AW-1:0]),
    .i_wr_data (w_lb1_rd),
    .o_rd_data (w_lb2_rd)
  );

  always_ff @(posedge clk) begin
    if (resp_valid) r_resp_d <= resp;
  end

  assign w_col2[0] = w_lb2_rd;
  assign w_col2[1] = w_lb1_rd;
  assign w_col2[2] = r_resp_d;

  // Column 2 of the window is the freshly read column; columns 0/1 are its history.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
      always_ff @(posedge clk) begin
        if (resp_valid) begin
          r_win[gi][1] <= w_col2[gi];
          r_win[gi][0] <= r_win[gi][1];
        end
      end
      assign w_grid[gi][0] = r_win[gi][0];
      assign w_grid[gi][1] = r_win[gi][1];
      assign w_grid[gi][2] = w_col2[gi];
    end
  endgenerate

  assign w_centre = w_grid[1][1];

  // Raster-earlier cells need strict >, later cells >=, so a plateau keeps its first pixel.
  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_cmp
      if (gi < 4) begin : g_before
        assign w_pass[gi] = w_centre > w_grid[gi / 3][gi % 3];
      end else if (gi == 4) begin : g_thr
        assign w_pass[gi] = w_centre > r_thresh;
      end else begin : g_after
        assign w_pass[gi] = w_centre >= w_grid[gi / 3][gi % 3];
      end
    end
  endgenerate

  assign w_corner    = r_s1_eval && (&w_pass);
  assign w_count_inc = sat_inc16(r_count, w_corner);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1_eval <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_x    <= '0;
      r_s1_y    <= '0;
    end else begin
      r_s1_eval <= resp_valid && (r_x >= X_W'(2)) && (r_y >= Y_W'(2));
      r_s1_last <= w_last;
      r_s1_x    <= r_x - X_W'(1);
      r_s1_y    <= r_y - Y_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      corner_valid <= 1'b0;
      corner_x     <= '0;
      corner_y     <= '0;
      frame_done   <= 1'b0;
      corner_count <= '0;
      r_count      <= '0;
    end else begin
      corner_valid <= w_corner;
      frame_done   <= r_s1_last;
      if (w_corner) begin
        corner_x <= r_s1_x;
        corner_y <= r_s1_y;
      end
      if (r_s1_last) begin
        corner_count <= w_count_inc;
        r_count      <= '0;
      end else begin
        r_count <= w_count_inc;
      end
    end
  end

endmodule

// File: tb/tb_harris_corner_nms.sv
// Directed frames on an 8x8 image; expected corners and frame completions
// are queued by the driver and matched by an independent monitor.
module tb_harris_corner_nms;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int RW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] resp;
  logic          resp_valid;
  logic [RW-1:0] threshold;
  logic          corner_valid;
  logic [7:0]    corner_x;
  logic [7:0]    corner_y;
  logic          frame_done;
  logic [15:0]   corner_count;

  always #5 clk = ~clk;

  harris_corner_nms #(.IMG_W(W), .IMG_H(H), .RESP_W(RW), .X_W(8), .Y_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .resp         (resp),
    .resp_valid   (resp_valid),
    .threshold    (threshold),
    .corner_valid (corner_valid),
    .corner_x     (corner_x),
    .corner_y     (corner_y),
    .frame_done   (frame_done),
    .corner_count (corner_count)
  );

  typedef struct {int x; int y; int t;} cexp_t;
  typedef struct {int cnt; int t;} fexp_t;

  cexp_t         cq[$];
  fexp_t         fq[$];
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;
  logic [RW-1:0] img [64];
  int            ex_x [4];
  int            ex_y [4];
  int            ex_n;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    cexp_t ce;
    fexp_t fe;
    if (corner_valid === 1'b1) begin
      if (cq.size() == 0) begin
        check("unexpected_corner_valid", 1, 0);
      end else begin
        ce = cq.pop_front();
        $display("corner   x=%0d y=%0d at cycle %0d (expected x=%0d y=%0d cycle %0d)",
                 corner_x, corner_y, cyc, ce.x, ce.y, ce.t);
        check("corner_x", corner_x, ce.x);
        check("corner_y", corner_y, ce.y);
        check("corner_latency", cyc, ce.t);
      end
    end
    if (frame_done === 1'b1) begin
      if (fq.size() == 0) begin
        check("unexpected_frame_done", 1, 0);
      end else begin
        fe = fq.pop_front();
        $display("frame    count=%0d at cycle %0d (expected count=%0d cycle %0d)",
                 corner_count, cyc, fe.cnt, fe.t);
        check("corner_count", corner_count, fe.cnt);
        check("frame_done_latency", cyc, fe.t);
      end
    end
  end

  task automatic fill_img(input logic [RW-1:0] v);
    for (int i = 0; i < 64; i++) img[i] = v;
    ex_n = 0;
  endtask

  task automatic expect_corner(input int x, input int y);
    ex_x[ex_n] = x;
    ex_y[ex_n] = y;
    ex_n++;
  endtask

  // Drives npix pixels of img; a corner at (cx,cy) is confirmed by pixel (cx+1,cy+1).
  task automatic run_frame(input logic [RW-1:0] thr, input int gap, input int npix);
    cexp_t ce;
    fexp_t fe;
    for (int i = 0; i < npix; i++) begin
      if (gap != 0) begin
        @(negedge clk);
        resp_valid = 1'b0;
        resp       = $urandom;
        threshold  = $urandom;
      end
      @(negedge clk);
      resp_valid = 1'b1;
      resp       = img[i];
      threshold  = (i == 0) ? thr : $urandom;
      for (int k = 0; k < ex_n; k++) begin
        if (i == (ex_y[k] + 1) * W + ex_x[k] + 1) begin
          ce.x = ex_x[k];
          ce.y = ex_y[k];
          ce.t = cyc + 2;
          cq.push_back(ce);
        end
      end
      if (i == 63) begin
        fe.cnt = ex_n;
        fe.t   = cyc + 2;
        fq.push_back(fe);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      resp_valid = 1'b0;
      resp       = $urandom;
    end
  endtask

  initial begin
    reset      = 1'b0;
    resp_valid = 1'b0;
    resp       = '0;
    threshold  = '0;
    repeat (3) @(negedge clk);
    check("reset_corner_valid", corner_valid, 0);
    check("reset_corner_x", corner_x, 0);
    check("reset_corner_y", corner_y, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_corner_count", corner_count, 0);
    reset = 1'b1;
    idle(2);

    // All-zero frame, threshold 0.
    fill_img('0);
    run_frame(32'd0, 0, 64);

    // Single peak, threshold 50, back-to-back with the previous frame.
    fill_img('0);
    img[4 * W + 3] = 32'd100;
    expect_corner(3, 4);
    run_frame(32'd50, 0, 64);

    // Same frame, threshold equal to the peak: strict compare rejects it.
    fill_img('0);
    img[4 * W + 3] = 32'd100;
    run_frame(32'd100, 0, 64);

    // Horizontal plateau: only the first raster position is a corner.
    fill_img('0);
    img[4 * W + 3] = 32'd100;
    img[4 * W + 4] = 32'd100;
    expect_corner(3, 4);
    run_frame(32'd0, 0, 64);

    // Border peaks are never evaluated.
    fill_img('0);
    img[3 * W + 0] = 32'd100;
    img[7 * W + 7] = 32'd100;
    img[0 * W + 3] = 32'd100;
    run_frame(32'd0, 0, 64);

    // Single peak with resp_valid every other cycle.
    fill_img('0);
    img[4 * W + 3] = 32'd100;
    expect_corner(3, 4);
    run_frame(32'd50, 1, 64);

    // Partial frame aborted by a one-cycle reset, then a full frame.
    fill_img('0);
    img[4 * W + 3] = 32'd100;
    run_frame(32'd50, 0, 20);
    @(negedge clk);
    resp_valid = 1'b0;
    reset      = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    expect_corner(3, 4);
    run_frame(32'd50, 0, 64);

    // Negative responses and threshold.
    fill_img(-32'sd10);
    img[2 * W + 2] = -32'sd5;
    expect_corner(2, 2);
    run_frame(-32'sd8, 0, 64);

    idle(8);
    check("corner_queue_drained", cq.size(), 0);
    check("frame_queue_drained", fq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
